k6502_core: RTL and testbench
=============================

Name: k6502_core

Overview:
- Cycle-based, reduced-instruction-set 6502-compatible CPU core: one bus cycle per clk.
- Drives a 16-bit address bus and a bidirectional 8-bit data bus to external ROM and SRAM.
- Provides a SYNC opcode-fetch strobe and debug visibility of its internal state for trace/checking benches.
- Any opcode outside the supported subset halts the core and raises debug_ex.

Parameters:
- X_BITS, 3: width of the cycle-state counter exposed on debug_x.

Ports:
- clk  in  1  Clock; all state changes on posedge.
- rst_n  in  1  Reset; synchronous, active-low; clock clk.
- a  out  16  Address bus.
- d  inout  8  Data bus. Driven by the core only when rw=1; high-Z otherwise.
- sync  out  1  High during opcode-fetch cycles.
- rw  out  1  1 = write cycle (core drives d); 0 = read cycle. Note: polarity is inverted versus a real 6502.
- debug_x  out  X_BITS  Current cycle index within the instruction; 0 = opcode fetch.
- debug_dl  out  16  Data latch: operand low/high bytes collected.
- debug_ir  out  8  Instruction register.
- debug_pc  out  16  Program counter.
- debug_sr  out  8  Status {N,V,1,B,D,I,Z,C}.
- debug_ra_data, debug_rx_data, debug_ry_data  out  8 each  A, X, Y registers.
- debug_ex  out  1  Sticky illegal-opcode/halt flag.

Behaviour:
- Reset (rst_n=0 at posedge):
  - A=X=Y=0, PC=0, SR=8'h24, IR=8'hEA, debug_x=0, ex=0.
  - Outputs: rw=0, sync=0, a=0.
- Reset vector: after rst_n rises, the core reads $FFFC (cycle R0), then $FFFD (R1), loads PC={hi,lo}, then starts opcode fetch.
- Bus timing:
  - a, rw and write data change only on posedge and stay stable for the whole cycle.
  - Read data on d is sampled at the end of the cycle (next posedge).
- Opcode fetch cycle (x=0): a=PC, sync=1, IR<=d, PC+1.
- Operand cycles: a=PC, PC+1.
- Supported opcodes and cycle counts:
  - LDA/LDX/LDY immediate (A9/A2/A0): 2 cycles.
  - LDA/LDX/LDY absolute (AD/AE/AC): 4 cycles; the last cycle reads the effective address.
  - STA/STX/STY absolute (8D/8E/8C): 4 cycles; the last cycle is a write with rw=1, a=addr, d=reg.
  - ADC/SBC/AND/ORA/EOR/CMP immediate (69/E9/29/09/49/C9): 2 cycles.
  - INX/INY/DEX/DEY (E8/C8/CA/88) and TAX/TAY/TXA/TYA (AA/A8/8A/98): 2 cycles, dummy read of PC without increment.
  - CLC/SEC (18/38) and NOP (EA): 2 cycles.
  - JMP absolute (4C): 3 cycles.
  - BEQ/BNE/BCS/BCC (F0/D0/B0/90): 2 cycles if not taken, 3 if taken. Offset is signed 8-bit, added to the PC of the next instruction, 16-bit wrap, no page-cross penalty.
- Flags:
  - Loads, transfers (except none), INC/DEC and logic ops set N and Z from the 8-bit result.
  - ADC: binary, {C,result}=A+imm+C; V=(A7==imm7)&&(res7!=A7). D flag is ignored.
  - SBC = ADC with ~imm.
  - CMP: C=(A>=imm), Z and N from A-imm; A unchanged.
  - Stores, JMP and branches affect no flags.
- Wrap rules: INX/INY/DEX/DEY wrap mod 256; PC wraps $FFFF->$0000.
- Illegal opcode: at the end of the fetch cycle, ex<=1 and the core freezes (no PC change, rw=0, sync=0) until reset.
- Reset mid-instruction: aborts immediately; the in-progress write is not completed beyond the current cycle.
- Bus address map for system benches:
  - ROM answers when rw=0 and a[15]=1.
  - SRAM at a[15:13]=000, 2 KB mirrored.
  - A write to $DEAD is the end-of-test marker.

Test Plan:
- Reset: hold rst_n=0 4 cycles, ROM $FFFC=00,$FFFD=80 -> reads at $FFFC,$FFFD, then first sync=1 with a=$8000; SR=$24.
- Load/store: A9 5A 8D 00 01 -> write cycle a=$0100 d=$5A rw=1 on the 4th cycle of STA; Z=0, N=0.
- ADC overflow: SEC? no: 18 A9 7F 69 01 -> A=$80, N=1, V=1, C=0, Z=0; then E9 80 with C=0 -> A=$FF, C=0.
- Loop: A2 03 CA D0 FD 8E AD DE -> X counts 3,2,1,0; BNE taken twice (3 cycles) then not taken (2 cycles); final write a=$DEAD d=$00.
- JMP: 4C 34 12 -> next sync cycle at a=$1234 exactly 3 cycles after the JMP fetch.
- Illegal opcode $02 -> debug_ex=1 at next posedge, sync stays 0, PC frozen; rst_n pulse clears ex and refetches vector.

Source files
------------

// File: rtl/k6502_core_if.sv
// Address/control half of the k6502 external bus: address, write strobe and
// opcode-fetch strobe, all registered inside the core.
interface k6502_core_if;
    logic [15:0] a;
    logic        rw;
    logic        sync;

    modport master (output a, output rw, output sync);
    modport slave  (input a, input rw, input sync);
endinterface

// File: rtl/k6502_core.sv
// Reduced 6502-compatible core, one bus cycle per clock. Bus handshake: every
// bus output changes only at posedge; read data on d is sampled at the posedge
// that ends the cycle; d is driven by the core only while rw=1.
module k6502_core #(
    parameter int X_BITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    k6502_core_if.master      bus,
    inout  wire  [7:0]        d,
    output logic [X_BITS-1:0] debug_x,
    output logic [15:0]       debug_dl,
    output logic [7:0]        debug_ir,
    output logic [15:0]       debug_pc,
    output logic [7:0]        debug_sr,
    output logic [7:0]        debug_ra_data,
    output logic [7:0]        debug_rx_data,
    output logic [7:0]        debug_ry_data,
    output logic              debug_ex
);

    typedef enum logic [2:0] {
        ST_BOOT, ST_VEC_LO, ST_VEC_HI, ST_RUN, ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_IMM, C_LDABS, C_STABS, C_IMPL, C_JMP, C_BR, C_ILL
    } op_cls_e;

    localparam logic [X_BITS-1:0] X0 = X_BITS'(0);
    localparam logic [X_BITS-1:0] X1 = X_BITS'(1);
    localparam logic [X_BITS-1:0] X2 = X_BITS'(2);
    localparam logic [X_BITS-1:0] X3 = X_BITS'(3);

    function automatic op_cls_e op_class(input logic [7:0] op);
        case (op)
            8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9,
            8'h29, 8'h09, 8'h49, 8'hC9:             op_class = C_IMM;
            8'hAD, 8'hAE, 8'hAC:                    op_class = C_LDABS;
            8'h8D, 8'h8E, 8'h8C:                    op_class = C_STABS;
            8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'hA8,
            8'h8A, 8'h98, 8'h18, 8'h38, 8'hEA:      op_class = C_IMPL;
            8'h4C:                                  op_class = C_JMP;
            8'hF0, 8'hD0, 8'hB0, 8'h90:             op_class = C_BR;
            default:                                op_class = C_ILL;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [X_BITS-1:0] x_q, x_d;
    logic [7:0]        ir_q, ir_d;
    logic [15:0]       pc_q, pc_d;
    logic [15:0]       dl_q, dl_d;
    logic [7:0]        sr_q, sr_d;
    logic [7:0]        ra_q, ra_d, rx_q, rx_d, ry_q, ry_d;
    logic              ex_q, ex_d;
    logic [15:0]       a_q, a_d;
    logic              rw_q, rw_d, sync_q, sync_d;
    logic [7:0]        dout_q, dout_d;

    op_cls_e     cls;
    logic        next_fetch, br_take, nz_en, ld_en;
    logic [7:0]  nz_val, ld_val, st_val;
    logic [8:0]  sum;
    logic [7:0]  addend;

    // Loads and stores pick the register from opcode bits [1:0]: 01=A, 10=X, 00=Y.
    always_comb begin
        case (ir_q[1:0])
            2'b01:   st_val = ra_q;
            2'b10:   st_val = rx_q;
            default: st_val = ry_q;
        endcase
        case (ir_q)
            8'hF0:   br_take = sr_q[1];
            8'hD0:   br_take = !sr_q[1];
            8'hB0:   br_take = sr_q[0];
            8'h90:   br_take = !sr_q[0];
            default: br_take = 1'b0;
        endcase
        addend = (ir_q == 8'hE9) ? ~d : d;
        sum    = {1'b0, ra_q} + {1'b0, addend} + {8'd0, sr_q[0]};
        cls    = op_class(ir_q);
    end

    always_comb begin
        state_d = state_q;  x_d  = x_q;   ir_d = ir_q;  pc_d = pc_q;
        dl_d    = dl_q;     sr_d = sr_q;  ra_d = ra_q;  rx_d = rx_q;
        ry_d    = ry_q;     ex_d = ex_q;  a_d  = a_q;   dout_d = dout_q;
        rw_d    = 1'b0;     sync_d = 1'b0;
        next_fetch = 1'b0;
        nz_en  = 1'b0;  nz_val = 8'd0;
        ld_en  = 1'b0;  ld_val = 8'd0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_VEC_LO;
                a_d     = 16'hFFFC;
            end
            ST_VEC_LO: begin
                dl_d[7:0] = d;
                state_d   = ST_VEC_HI;
                a_d       = 16'hFFFD;
            end
            ST_VEC_HI: begin
                pc_d    = {d, dl_q[7:0]};
                x_d     = X0;
                a_d     = {d, dl_q[7:0]};
                sync_d  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (x_q == X0) begin
                    ir_d = d;
                    if (op_class(d) == C_ILL) begin
                        ex_d    = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + 16'd1;
                        x_d  = X1;
                        a_d  = pc_q + 16'd1;
                    end
                end else if (x_q == X1) begin
                    case (cls)
                        C_IMM: begin
                            pc_d       = pc_q + 16'd1;
                            next_fetch = 1'b1;
                            case (ir_q)
                                8'h69, 8'hE9: begin
                                    ra_d    = sum[7:0];
                                    sr_d[0] = sum[8];
                                    sr_d[6] = (ra_q[7] == addend[7]) && (sum[7] != ra_q[7]);
                                    nz_en = 1'b1; nz_val = sum[7:0];
                                end
                                8'h29:   begin ra_d = ra_q & d; nz_en = 1'b1; nz_val = ra_q & d; end
                                8'h09:   begin ra_d = ra_q | d; nz_en = 1'b1; nz_val = ra_q | d; end
                                8'h49:   begin ra_d = ra_q ^ d; nz_en = 1'b1; nz_val = ra_q ^ d; end
                                8'hC9: begin
                                    sr_d[0] = (ra_q >= d);
                                    nz_en = 1'b1; nz_val = ra_q - d;
                                end
                                default: begin ld_en = 1'b1; ld_val = d; end
                            endcase
                        end
                        C_IMPL: begin
                            next_fetch = 1'b1;
                            case (ir_q)
                                8'hE8: begin rx_d = rx_q + 8'd1; nz_en = 1'b1; nz_val = rx_q + 8'd1; end
                                8'hC8: begin ry_d = ry_q + 8'd1; nz_en = 1'b1; nz_val = ry_q + 8'd1; end
                                8'hCA: begin rx_d = rx_q - 8'd1; nz_en = 1'b1; nz_val = rx_q - 8'd1; end
                                8'h88: begin ry_d = ry_q - 8'd1; nz_en = 1'b1; nz_val = ry_q - 8'd1; end
                                8'hAA: begin rx_d = ra_q; nz_en = 1'b1; nz_val = ra_q; end
                                8'hA8: begin ry_d = ra_q; nz_en = 1'b1; nz_val = ra_q; end
                                8'h8A: begin ra_d = rx_q; nz_en = 1'b1; nz_val = rx_q; end
                                8'h98: begin ra_d = ry_q; nz_en = 1'b1; nz_val = ry_q; end
                                8'h18: sr_d[0] = 1'b0;
                                8'h38: sr_d[0] = 1'b1;
                                default: ;
                            endcase
                        end
                        C_BR: begin
                            pc_d = pc_q + 16'd1;
                            if (br_take) begin
                                dl_d[7:0] = d;
                                x_d       = X2;
                                a_d       = pc_q + 16'd1;
                            end else begin
                                next_fetch = 1'b1;
                            end
                        end
                        default: begin
                            dl_d[7:0] = d;
                            pc_d      = pc_q + 16'd1;
                            x_d       = X2;
                            a_d       = pc_q + 16'd1;
                        end
                    endcase
                end else if (x_q == X2) begin
                    case (cls)
                        C_JMP: begin
                            pc_d       = {d, dl_q[7:0]};
                            next_fetch = 1'b1;
                        end
                        C_BR: begin
                            pc_d       = pc_q + {{8{dl_q[7]}}, dl_q[7:0]};
                            next_fetch = 1'b1;
                        end
                        default: begin
                            dl_d[15:8] = d;
                            pc_d       = pc_q + 16'd1;
                            x_d        = X3;
                            a_d        = {d, dl_q[7:0]};
                            if (cls == C_STABS) begin
                                rw_d   = 1'b1;
                                dout_d = st_val;
                            end
                        end
                    endcase
                end else begin
                    if (cls == C_LDABS) begin
                        ld_en = 1'b1; ld_val = d;
                    end
                    next_fetch = 1'b1;
                end

                if (next_fetch) begin
                    x_d    = X0;
                    a_d    = pc_d;
                    sync_d = 1'b1;
                end
            end
            ST_HALT: ;
            default: state_d = ST_BOOT;
        endcase

        if (ld_en) begin
            case (ir_q[1:0])
                2'b01:   ra_d = ld_val;
                2'b10:   rx_d = ld_val;
                default: ry_d = ld_val;
            endcase
            nz_en  = 1'b1;
            nz_val = ld_val;
        end
        if (nz_en) begin
            sr_d[7] = nz_val[7];
            sr_d[1] = (nz_val == 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;  x_q  <= X0;      ir_q <= 8'hEA;  pc_q <= 16'd0;
            dl_q    <= 16'd0;    sr_q <= 8'h24;   ra_q <= 8'd0;   rx_q <= 8'd0;
            ry_q    <= 8'd0;     ex_q <= 1'b0;    a_q  <= 16'd0;  rw_q <= 1'b0;
            sync_q  <= 1'b0;     dout_q <= 8'd0;
        end else begin
            state_q <= state_d;  x_q  <= x_d;     ir_q <= ir_d;   pc_q <= pc_d;
            dl_q    <= dl_d;     sr_q <= sr_d;    ra_q <= ra_d;   rx_q <= rx_d;
            ry_q    <= ry_d;     ex_q <= ex_d;    a_q  <= a_d;    rw_q <= rw_d;
            sync_q  <= sync_d;   dout_q <= dout_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.rw   = rw_q;
    assign bus.sync = sync_q;
    assign d        = rw_q ? dout_q : 8'hzz;

    assign debug_x       = x_q;
    assign debug_dl      = dl_q;
    assign debug_ir      = ir_q;
    assign debug_pc      = pc_q;
    assign debug_sr      = sr_q;
    assign debug_ra_data = ra_q;
    assign debug_rx_data = rx_q;
    assign debug_ry_data = ry_q;
    assign debug_ex      = ex_q;

endmodule

// File: tb/tb_k6502_core.sv
// Directed bench for k6502_core: 64 KB memory model on the bus, cycle-exact
// checks of vector fetch, ALU/flag table, stores, branches, JMP and halt.
module tb_k6502_core;

  logic        clk;
  logic        rst_n;
  wire  [7:0]  d_bus;
  logic [2:0]  debug_x;
  logic [15:0] debug_dl, debug_pc;
  logic [7:0]  debug_ir, debug_sr, debug_ra_data, debug_rx_data, debug_ry_data;
  logic        debug_ex;

  logic [7:0]  mem [0:65535];
  logic [23:0] exp_q[$];
  int          checks_cnt;
  int          fail_cnt;

  k6502_core_if bus ();

  k6502_core #(.X_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .d(d_bus),
    .debug_x(debug_x), .debug_dl(debug_dl), .debug_ir(debug_ir),
    .debug_pc(debug_pc), .debug_sr(debug_sr),
    .debug_ra_data(debug_ra_data), .debug_rx_data(debug_rx_data),
    .debug_ry_data(debug_ry_data), .debug_ex(debug_ex)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign d_bus = (bus.rw === 1'b0) ? mem[bus.a] : 8'hzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // write scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rw === 1'b1) begin
      mem[bus.a] = d_bus;
      if (exp_q.size() == 0) check("wr_unexpected", exp_q.size(), 1);
      else check("wr", {8'd0, bus.a, d_bus}, {8'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot();
    rst_n = 1'b0;
    repeat (4) tick();
    check("rst_a", bus.a, 16'h0000);
    check("rst_rw", bus.rw, 1'b0);
    check("rst_sync", bus.sync, 1'b0);
    check("rst_pc", debug_pc, 16'h0000);
    check("rst_sr", debug_sr, 8'h24);
    check("rst_ir", debug_ir, 8'hEA);
    check("rst_x", debug_x, 3'd0);
    check("rst_ex", debug_ex, 1'b0);
    check("rst_regs", {debug_ra_data, debug_rx_data, debug_ry_data}, 24'd0);
    rst_n = 1'b1;
    tick();
    check("vec_lo_a", bus.a, 16'hFFFC);
    tick();
    check("vec_hi_a", bus.a, 16'hFFFD);
    tick();
    check("boot_sync", bus.sync, 1'b1);
    check("boot_a", bus.a, 16'h8000);
  endtask

  task automatic cycles_to_sync(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.sync !== 1'b1 && n < 8);
  endtask

  localparam int N_ALU = 21;
  logic [7:0] t_op  [N_ALU] = '{8'h18, 8'hA9, 8'h69, 8'hE9, 8'hC9, 8'h29, 8'h09, 8'h49, 8'h18, 8'h38,
                                8'hAA, 8'hCA, 8'hE8, 8'h88, 8'h98, 8'hC8, 8'hA8, 8'h8A, 8'hA2, 8'hA0, 8'hEA};
  logic [7:0] t_imm [N_ALU] = '{8'h00, 8'h7F, 8'h01, 8'h80, 8'hFF, 8'h0F, 8'hF0, 8'hFF, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 8'h00};
  int         t_len [N_ALU] = '{1, 2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 1};
  logic [7:0] t_a   [N_ALU] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] t_x   [N_ALU] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80};
  logic [7:0] t_y   [N_ALU] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h01};
  logic [7:0] t_sr  [N_ALU] = '{8'h24, 8'h24, 8'hE4, 8'hA4, 8'h27, 8'h25, 8'hA5, 8'h27, 8'h26, 8'h27,
                                8'h27, 8'hA5, 8'h27, 8'hA5, 8'hA5, 8'h27, 8'hA5, 8'h27, 8'hA5, 8'h25, 8'h25};

  int br_n [4] = '{3, 2, 2, 3};
  logic [15:0] br_a [4] = '{16'h8006, 16'h8008, 16'h800A, 16'h8000};

  initial begin
    int n;
    logic [15:0] addr;
    checks_cnt = 0;
    fail_cnt   = 0;
    rst_n      = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;

    // ALU / flag / transfer table
    addr = 16'h8000;
    for (int i = 0; i < N_ALU; i++) begin
      mem[addr] = t_op[i];
      if (t_len[i] == 2) mem[addr + 16'd1] = t_imm[i];
      addr = addr + 16'(t_len[i]);
    end
    boot();
    addr = 16'h8000;
    for (int i = 0; i < N_ALU; i++) begin
      tick();
      tick();
      addr = addr + 16'(t_len[i]);
      check($sformatf("alu%0d_a", i), bus.a, addr);
      check($sformatf("alu%0d_sync", i), bus.sync, 1'b1);
      check($sformatf("alu%0d_ra", i), debug_ra_data, t_a[i]);
      check($sformatf("alu%0d_rx", i), debug_rx_data, t_x[i]);
      check($sformatf("alu%0d_ry", i), debug_ry_data, t_y[i]);
      check($sformatf("alu%0d_sr", i), debug_sr, t_sr[i]);
    end

    // LDA #$5A ; STA $0100
    {mem[16'h8000], mem[16'h8001], mem[16'h8002], mem[16'h8003], mem[16'h8004]} =
      {8'hA9, 8'h5A, 8'h8D, 8'h00, 8'h01};
    exp_q.push_back({16'h0100, 8'h5A});
    boot();
    tick();
    tick();
    check("lda_ra", debug_ra_data, 8'h5A);
    check("lda_sr", debug_sr, 8'h24);
    tick();
    check("sta_x1_rw", bus.rw, 1'b0);
    tick();
    tick();
    check("sta_wr_a", bus.a, 16'h0100);
    check("sta_wr_rw", bus.rw, 1'b1);
    check("sta_wr_d", d_bus, 8'h5A);
    check("sta_wr_sync", bus.sync, 1'b0);
    tick();
    check("sta_next_a", bus.a, 16'h8005);
    check("sta_next_rw", bus.rw, 1'b0);
    check("sta_mem", mem[16'h0100], 8'h5A);

    // LDX #3 ; loop: DEX ; BNE loop ; STX $DEAD
    {mem[16'h8000], mem[16'h8001], mem[16'h8002], mem[16'h8003],
     mem[16'h8004], mem[16'h8005], mem[16'h8006], mem[16'h8007]} =
      {8'hA2, 8'h03, 8'hCA, 8'hD0, 8'hFD, 8'h8E, 8'hAD, 8'hDE};
    exp_q.push_back({16'hDEAD, 8'h00});
    boot();
    tick();
    tick();
    check("ldx_rx", debug_rx_data, 8'h03);
    for (int it = 0; it < 3; it++) begin
      tick();
      tick();
      check($sformatf("dex%0d_rx", it), debug_rx_data, 8'(2 - it));
      check($sformatf("dex%0d_a", it), bus.a, 16'h8003);
      cycles_to_sync(n);
      check($sformatf("bne%0d_cycles", it), n, (it < 2) ? 3 : 2);
      check($sformatf("bne%0d_a", it), bus.a, (it < 2) ? 16'h8002 : 16'h8005);
    end
    tick();
    tick();
    tick();
    check("stx_a", bus.a, 16'hDEAD);
    check("stx_rw", bus.rw, 1'b1);
    check("stx_d", d_bus, 8'h00);
    tick();

    // LDA #0 ; BEQ +2 ; (skip) ; BCS +$10 ; BNE +$10 ; BCC -12
    {mem[16'h8000], mem[16'h8001], mem[16'h8002], mem[16'h8003]} = {8'hA9, 8'h00, 8'hF0, 8'h02};
    {mem[16'h8006], mem[16'h8007], mem[16'h8008], mem[16'h8009]} = {8'hB0, 8'h10, 8'hD0, 8'h10};
    {mem[16'h800A], mem[16'h800B]} = {8'h90, 8'hF4};
    boot();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      cycles_to_sync(n);
      check($sformatf("br%0d_cycles", i), n, br_n[i]);
      check($sformatf("br%0d_a", i), bus.a, br_a[i]);
    end

    // JMP $1234
    {mem[16'h8000], mem[16'h8001], mem[16'h8002]} = {8'h4C, 8'h34, 8'h12};
    boot();
    cycles_to_sync(n);
    check("jmp_cycles", n, 3);
    check("jmp_a", bus.a, 16'h1234);
    check("jmp_pc", debug_pc, 16'h1234);

    // illegal opcode halts until reset
    mem[16'h8000] = 8'h02;
    boot();
    tick();
    check("ill_ex", debug_ex, 1'b1);
    check("ill_sync", bus.sync, 1'b0);
    check("ill_rw", bus.rw, 1'b0);
    check("ill_pc", debug_pc, 16'h8000);
    repeat (3) tick();
    check("halt_ex", debug_ex, 1'b1);
    check("halt_sync", bus.sync, 1'b0);
    check("halt_pc", debug_pc, 16'h8000);
    check("halt_a", bus.a, 16'h8000);
    boot();
    check("reboot_ex", debug_ex, 1'b0);

    check("wr_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
